// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus field widths and R/W bit values.
package i2c_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int BYTE_WIDTH = 8;

  localparam logic [ADDR_WIDTH-1:0] GCALL_ADDR = 7'h00;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_LOAD,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and byte-stream handshake between the I2C target and its user logic.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_gcall;
  logic                  tx_req;
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  rw;
  logic                  busy;
  logic                  nack_seen;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, rx_gcall, tx_req, rw, busy, nack_seen
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, rx_gcall, tx_req, rw, busy, nack_seen
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronizers with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Shift raw pins through the chain; keep one extra delayed copy for edge detection.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // SDA may only move while SCL is high for START/STOP; SCL must be high on both samples.
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: address match, write-byte strobe, read-byte request handshake.
// Open-drain SDA only (sda_oe pulls low). Optional general-call receive is enabled by
// defining I2C_SLAVE_GCALL_EN; without it address 7'h00 is an ordinary mismatch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free or not yet addressed
// ADDR     | shifting 7 address bits plus R/W
// ADDR_ACK | driving ACK for a matched address
// RX_BYTE  | shifting in a write byte
// RX_ACK   | driving ACK for a received byte
// TX_LOAD  | capturing tx_data one cycle after tx_req
// TX_BYTE  | shifting out a read byte on SCL falls
// TX_ACK   | sampling master ACK/NACK after a read byte
// IGNORE   | not addressed or read ended; wait for START/STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'b0011011,
  parameter int                    SYNC_STAGES = 2
) (
  input logic        clk_50,
  input logic        rst,
  i2c_slave_if.slave bus
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_50    (clk_50),
    .rst       (rst),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e            state_q;
  logic [2:0]            bit_cnt_q;
  logic [BYTE_WIDTH-1:0] shreg_q;
  logic                  ack_drv_q;
  logic                  tx_pend_q;
  logic                  sda_oe_q;
  logic [BYTE_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  tx_req_q;
  logic                  rw_q;
  logic                  busy_q;
  logic                  nack_q;
  logic [BYTE_WIDTH-1:0] shift_d;
  logic                  gcall_hit_d;
  logic                  addr_match_d;

  // Byte as it will look once the bit on this SCL rise is shifted in.
  assign shift_d = {shreg_q[BYTE_WIDTH-2:0], sda_s};

`ifdef I2C_SLAVE_GCALL_EN
  logic gcall_q;
  logic rx_gcall_q;
  assign gcall_hit_d = (shift_d[7:1] == GCALL_ADDR) && (shift_d[0] == RW_WRITE);
  assign bus.rx_gcall = rx_gcall_q;

  // Remember that the transfer was a general call and tag each received byte with it.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      gcall_q    <= 1'b0;
      rx_gcall_q <= 1'b0;
    end else begin
      if (state_q == ADDR && scl_rise && bit_cnt_q == 3'd7)
        gcall_q <= gcall_hit_d;
      if (state_q == RX_BYTE && scl_rise && bit_cnt_q == 3'd7 && !start_det && !stop_det)
        rx_gcall_q <= gcall_q;
    end
  end
`else
  assign gcall_hit_d  = 1'b0;
  assign bus.rx_gcall = 1'b0;
`endif

  assign addr_match_d = (shift_d[7:1] == SLAVE_ADDR) || gcall_hit_d;

  // Transfer FSM; START/STOP override every state and release the bus.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ack_drv_q  <= 1'b0;
      tx_pend_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
      if (start_det || stop_det) begin
        state_q   <= start_det ? ADDR : IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        ack_drv_q <= 1'b0;
        tx_pend_q <= 1'b0;
        if (stop_det) rw_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shreg_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_match_d) begin
                rw_q    <= shift_d[0];
                busy_q  <= 1'b1;
                state_q <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            sda_oe_q  <= ~ack_drv_q;
            ack_drv_q <= ~ack_drv_q;
            if (ack_drv_q) begin
              if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                tx_req_q <= 1'b1;
                state_q  <= TX_LOAD;
              end else begin
                state_q  <= RX_BYTE;
              end
            end
          end
          RX_BYTE: if (scl_rise) begin
            shreg_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= shift_d;
              rx_valid_q <= 1'b1;
              state_q    <= RX_ACK;
            end
          end
          // After a master ACK SCL is still high, so bit 7 waits for the next fall.
          TX_LOAD: begin
            shreg_q   <= bus.tx_data;
            bit_cnt_q <= '0;
            state_q   <= TX_BYTE;
            if (!tx_pend_q) sda_oe_q <= ~bus.tx_data[7];
          end
          TX_BYTE: if (scl_fall) begin
            if (tx_pend_q) begin
              sda_oe_q  <= ~shreg_q[7];
              tx_pend_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= TX_ACK;
              end else begin
                shreg_q  <= {shreg_q[BYTE_WIDTH-2:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
              end
            end
          end
          TX_ACK: if (scl_rise) begin
            if (!sda_s) begin
              tx_req_q  <= 1'b1;
              tx_pend_q <= 1'b1;
              state_q   <= TX_LOAD;
            end else begin
              nack_q  <= 1'b1;
              state_q <= IGNORE;
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.rw        = rw_q;
  assign bus.busy      = busy_q;
  assign bus.nack_seen = nack_q;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) endpoint. It answers the transactions issued by the team's I2C master on the same SDA/SCL bus.
- Samples SCL/SDA on clk_50 with synchronizers, then detects START, STOP and repeated START.
- Matches a 7-bit address and ACKs it. Receives write bytes into a strobe interface and serves read bytes from a byte-request handshake.
- Drives SDA open-drain only, through a pull-low enable. It never drives SCL.

Parameters:
- SLAVE_ADDR, 7'b0011011: own 7-bit bus address.
- SYNC_STAGES, 2: flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk_50  input  1  system clock, 50 MHz, at least 16x SCL rate.
- rst  input  1  asynchronous active-high reset.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release (pad is tristated externally).
- rx_data  output  8  last received write byte, MSB first on the bus.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_gcall  output  1  qualifies rx_valid: byte arrived under a general-call address.
- tx_req  output  1  one-cycle strobe asking for the next read byte.
- tx_data  input  8  read byte; sampled exactly 1 cycle after tx_req.
- rw  output  1  R/W bit of the current transfer (1 = read); held until STOP.
- busy  output  1  high from an address match until STOP or START.
- nack_seen  output  1  one-cycle strobe when the master NACKs a read byte.

Behaviour:
- Reset: sda_oe=0, rx_data=0, rx_valid=0, rx_gcall=0, tx_req=0, rw=0, busy=0, nack_seen=0; FSM enters IDLE and synchronizer outputs are set to 1. Reset asserted mid-byte releases SDA immediately, because it is asynchronous.
- Edge detect on the synchronized signals:
  - scl_rise, scl_fall.
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
- START or STOP from any state takes priority over everything else. START goes to ADDR with bit counter 0; STOP goes to IDLE. Both release sda_oe and drop busy.
- Bit timing:
  - Bits are sampled on scl_rise.
  - sda_oe changes only in the cycle after scl_fall, never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE.
- ADDR:
  - Shift 8 bits (7 address bits, then R/W).
  - On the 8th scl_rise, compare against SLAVE_ADDR.
  - Match: latch rw, set busy, go to ADDR_ACK. Mismatch: go to IGNORE, where SDA is never driven until START or STOP.
- ADDR_ACK: assert sda_oe on the next scl_fall and release it on the following scl_fall. If rw=0, go to RX_BYTE. If rw=1, pulse tx_req and go to TX_LOAD.
- RX_BYTE: shift 8 bits. On the 8th scl_rise, update rx_data and pulse rx_valid for 1 cycle, then go to RX_ACK. Every received byte is ACKed.
- RX_ACK: same drive/release timing as ADDR_ACK, then return to RX_BYTE.
- TX_LOAD: capture tx_data into the shift register, then go to TX_BYTE. Bit 7 is driven at the SCL low phase that follows (sda_oe = ~bit).
- TX_BYTE: shift out on each scl_fall. After the 8th bit's scl_fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on scl_rise.
  - 0 (ACK): pulse tx_req and go to TX_LOAD.
  - 1 (NACK): pulse nack_seen and go to IGNORE until STOP or START.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary. A byte is complete only on the 8th rising edge.
- Repeated START mid-byte aborts the partial byte: no rx_valid, and the new address phase begins.
- A glitch on SDA while SCL is high and the FSM is in IDLE still counts as START/STOP; no filtering beyond the synchronizers.

Optional Feature:
- Macro I2C_SLAVE_GCALL_EN.
- Defined: address 7'h00 with R/W=0 is ACKed. The following bytes are received as in RX_BYTE, with rx_gcall=1 alongside each rx_valid. Address 7'h00 with R/W=1 goes to IGNORE.
- Undefined: 7'h00 is treated as a mismatch and rx_gcall is tied 0.

Decomposition:
- Shared package i2c_pkg holds:
  - FSM state enum;
  - ADDR_WIDTH=7, BYTE_WIDTH=8;
  - GCALL_ADDR=7'h00;
  - RW_READ=1/RW_WRITE=0 constants, shared with the master.
- One sub-module, i2c_bus_sync: SYNC_STAGES synchronizer for SCL/SDA plus edge and START/STOP detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write: START, 0x1B+W, 0x5A, STOP -> ACK on address and data; rx_valid once with rx_data=0x5A; busy falls on STOP.
- Read: START, 0x1B+R, tx_data=0xDE; master NACKs -> bus sees 11011110, nack_seen pulses once, sda_oe=0 after the ACK slot.
- Mismatch: START, 0x1C+W, 0xFF -> sda_oe stays 0 throughout; no rx_valid; busy=0.
- Repeated START: write 0x1B+W, 4 data bits, then START, 0x1B+R -> no rx_valid; rw=1; tx_req pulses.
- Reset mid-read: assert rst while bit 3 of 0xDE is being driven -> sda_oe=0 in the same cycle; FSM in IDLE; next START is handled normally.
- General call, I2C_SLAVE_GCALL_EN defined: START, 0x00+W, 0x3C -> ACK; rx_data=0x3C with rx_gcall=1. Undefined: no ACK.
